// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM channel-1 arbiter.
package sdram_arb_pkg;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DIN_W  = 16;
    localparam int unsigned DOUT_W = 128;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rnw;
        logic              is128;
        logic [DIN_W-1:0]  din;
    } slot_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection: round-robin after `last`, or fixed priority (index 0 highest).
module arb_rr_pick
    import sdram_arb_pkg::*;
(
    input  logic [NREQ-1:0] pending,
    input  logic [1:0]      last,
    input  logic            rr_mode,
    output logic            valid,
    output logic [1:0]      idx
);

    logic [2:0] cand;

    always_comb begin
        valid = |pending;
        idx   = 2'd0;
        cand  = 3'd0;
        if (rr_mode) begin
            // Walk the ring farthest-first so the nearest pending requester after `last` wins.
            for (int off = NREQ; off >= 1; off--) begin
                cand = {1'b0, last} + 3'(off);
                if (cand >= 3'(NREQ)) begin
                    cand = cand - 3'(NREQ);
                end
                if (pending[cand[1:0]]) begin
                    idx = cand[1:0];
                end
            end
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (pending[k]) begin
                    idx = 2'(k);
                end
            end
        end
    end

endmodule

// File: rtl/sdram_ch1_arbiter.sv
// Shares SDRAM channel 1 among three requesters: captures request pulses, issues one req edge
// per access, completes on the ready rising edge or on a wait timeout.
module sdram_ch1_arbiter
    import sdram_arb_pkg::*;
#(
    parameter bit          RR_MODE = 1'b1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                        clk1x,
    input  logic                        reset,
    input  logic [NREQ-1:0]             rq_req,
    input  logic [NREQ-1:0][ADDR_W-1:0] rq_addr,
    input  logic [NREQ-1:0]             rq_rnw,
    input  logic [NREQ-1:0]             rq_128,
    input  logic [NREQ-1:0][DIN_W-1:0]  rq_din,
    output logic [NREQ-1:0]             rq_done,
    output logic [NREQ-1:0]             rq_timeout,
    output logic [DOUT_W-1:0]           rq_dout,
    output logic [NREQ-1:0]             err_overrun,
    output logic                        busy,
    output logic [1:0]                  grant_id,
    output logic                        ram_req,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DIN_W-1:0]            ram_din,
    output logic                        ram_rnw,
    output logic                        ram_128,
    input  logic                        ram_ready,
    input  logic [DOUT_W-1:0]           ram_dout
);

    localparam logic [9:0] CntLast = 10'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    slot_t [NREQ-1:0] slot_q;
    logic [NREQ-1:0]  pending_q;
    logic [NREQ-1:0]  slot_free;
    logic [NREQ-1:0]  accept;
    logic [1:0]       last_q;
    logic             ready_1_q;
    logic             timed_out_q;
    logic [9:0]       cnt_q;
    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             ready_edge;

    arb_rr_pick u_pick (
        .pending (pending_q),
        .last    (last_q),
        .rr_mode (RR_MODE),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    assign ready_edge = ram_ready & ~ready_1_q;
    assign busy       = (state_q != StIdle);
    assign ram_req    = (state_q == StIssue);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_valid) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (ready_edge || cnt_q == CntLast) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The granted slot stays occupied until its DONE cycle, when it may be refilled at once.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            slot_free[i] = ~pending_q[i] | (state_q == StDone && grant_id == 2'(i));
        end
        accept     = rq_req & slot_free;
        rq_done    = '0;
        rq_timeout = '0;
        if (state_q == StDone) begin
            rq_done[grant_id]    = 1'b1;
            rq_timeout[grant_id] = timed_out_q;
        end
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            pending_q   <= '0;
            err_overrun <= '0;
            last_q      <= 2'd2;
            ready_1_q   <= 1'b0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
            grant_id    <= '0;
            rq_dout     <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_rnw     <= 1'b0;
            ram_128     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_1_q   <= ram_ready;
            err_overrun <= err_overrun | (rq_req & ~slot_free);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (accept[i]) begin
                    slot_q[i]    <= '{addr: rq_addr[i], rnw: rq_rnw[i], is128: rq_128[i],
                                      din: rq_din[i]};
                    pending_q[i] <= 1'b1;
                end else if (state_q == StDone && grant_id == 2'(i)) begin
                    pending_q[i] <= 1'b0;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        ram_addr <= slot_q[pick_idx].addr;
                        ram_din  <= slot_q[pick_idx].din;
                        ram_rnw  <= slot_q[pick_idx].rnw;
                        ram_128  <= slot_q[pick_idx].is128;
                    end
                end
                StIssue: cnt_q <= '0;
                StWait: begin
                    if (ready_edge) begin
                        if (ram_rnw) rq_dout <= ram_dout;
                    end else if (cnt_q == CntLast) begin
                        timed_out_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                StDone: begin
                    last_q      <= grant_id;
                    timed_out_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ch1_arbiter.sv
// Randomised scoreboard bench for sdram_ch1_arbiter with a transaction-level SDRAM responder.
module tb_sdram_ch1_arbiter;
    import sdram_arb_pkg::*;

    localparam int TO  = 15;
    localparam int INF = 32'h7fffffff;

    logic clk1x = 1'b0;
    always #5 clk1x = ~clk1x;

    logic                        reset;
    logic [NREQ-1:0]             rq_req, rq_rnw, rq_128;
    logic [NREQ-1:0][ADDR_W-1:0] rq_addr;
    logic [NREQ-1:0][DIN_W-1:0]  rq_din;
    logic [NREQ-1:0]             rq_done, rq_timeout, err_overrun;
    logic [DOUT_W-1:0]           rq_dout;
    logic                        busy, ram_req, ram_rnw, ram_128;
    logic [1:0]                  grant_id;
    logic [ADDR_W-1:0]           ram_addr;
    logic [DIN_W-1:0]            ram_din;
    logic                        ram_ready = 1'b0;
    logic [DOUT_W-1:0]           ram_dout = '0;

    sdram_ch1_arbiter #(.RR_MODE(1'b1), .TIMEOUT(TO)) dut (
        .clk1x(clk1x), .reset(reset), .rq_req(rq_req), .rq_addr(rq_addr), .rq_rnw(rq_rnw),
        .rq_128(rq_128), .rq_din(rq_din), .rq_done(rq_done), .rq_timeout(rq_timeout),
        .rq_dout(rq_dout), .err_overrun(err_overrun), .busy(busy), .grant_id(grant_id),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_din(ram_din), .ram_rnw(ram_rnw),
        .ram_128(ram_128), .ram_ready(ram_ready), .ram_dout(ram_dout)
    );

    logic [NREQ-1:0]             f_req = '0, f_done, f_timeout, f_err;
    logic [NREQ-1:0][ADDR_W-1:0] f_addr = '0;
    logic [DOUT_W-1:0]           f_dout;
    logic                        f_busy, f_ram_req, f_ram_rnw, f_ram_128;
    logic                        f_ready = 1'b0;
    logic [1:0]                  f_grant_id;
    logic [ADDR_W-1:0]           f_ram_addr;
    logic [DIN_W-1:0]            f_ram_din;

    sdram_ch1_arbiter #(.RR_MODE(1'b0), .TIMEOUT(TO)) dut_fix (
        .clk1x(clk1x), .reset(reset), .rq_req(f_req), .rq_addr(f_addr), .rq_rnw(3'b111),
        .rq_128(3'b000), .rq_din('0), .rq_done(f_done), .rq_timeout(f_timeout),
        .rq_dout(f_dout), .err_overrun(f_err), .busy(f_busy), .grant_id(f_grant_id),
        .ram_req(f_ram_req), .ram_addr(f_ram_addr), .ram_din(f_ram_din), .ram_rnw(f_ram_rnw),
        .ram_128(f_ram_128), .ram_ready(f_ready), .ram_dout('0)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk1x) cyc <= cyc + 1;

    // Reference model: requester slots, sticky overrun flags, last grant and last read data.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rnw;
        logic              is128;
        logic [DIN_W-1:0]  din;
    } req_t;
    typedef struct {
        int                id;
        bit                to;
        int                at;
        logic [DOUT_W-1:0] dout;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    req_t              m_slot[NREQ];
    bit                m_pend[NREQ];
    int                m_issue[NREQ];
    int                m_done[NREQ];
    logic [NREQ-1:0]   m_err;
    int                m_last;
    logic [DOUT_W-1:0] m_dout;
    exp_t              sbq[$];

    bit                manual, stim_on, force_rdy;
    int                req_pct, manual_reqs, done_seen, last_req_cyc;
    int                rdy_at, rdy_len;
    logic [DOUT_W-1:0] rdy_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit eff_pend(input int i, input int t);
        return m_pend[i] && !(m_done[i] <= t);
    endfunction

    // A requester can win at the ram_req cycle c only if it was pending in the IDLE cycle c-1.
    function automatic bit eligible(input int i, input int c);
        return eff_pend(i, c - 1) && m_issue[i] <= c - 2;
    endfunction

    function automatic bit any_pend();
        bit p = 1'b0;
        for (int i = 0; i < 3; i++) p |= eff_pend(i, cyc);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i]  = 1'b0;
            m_issue[i] = 0;
            m_done[i]  = INF;
        end
        m_err        = '0;
        m_last       = 2;
        m_dout       = '0;
        sbq.delete();
        rdy_at       = -100;
        rdy_len      = 0;
        last_req_cyc = -100;
    endtask

    task automatic stim_cycle();
        logic [31:0] rnd;
        @(posedge clk1x);
        #1;
        for (int i = 0; i < 3; i++) begin
            rnd        = $urandom();
            rq_addr[i] = {rnd[26:1], 1'b0};
            rq_din[i]  = 16'($urandom());
            rq_rnw[i]  = rnd[31];
            rq_128[i]  = rnd[30];
            rq_req[i]  = stim_on && ($urandom_range(99) < req_pct);
            if (rq_req[i]) begin
                if (eff_pend(i, cyc)) begin
                    m_err[i] = 1'b1;
                end else begin
                    m_pend[i]        = 1'b1;
                    m_issue[i]       = cyc;
                    m_done[i]        = INF;
                    m_slot[i].addr   = rq_addr[i];
                    m_slot[i].rnw    = rq_rnw[i];
                    m_slot[i].is128  = rq_128[i];
                    m_slot[i].din    = rq_din[i];
                end
            end
        end
    endtask

    // SDRAM side: check the issued access and decide how the controller answers it.
    task automatic ram_side(input int c);
        int   w;
        int   d;
        exp_t e;
        chk("ram_req_gap", 128'(c - last_req_cyc >= 3), 128'd1);
        last_req_cyc = c;
        w = -1;
        for (int off = 1; off <= 3; off++) begin
            int j;
            j = (m_last + off) % 3;
            if (w < 0 && eligible(j, c)) w = j;
        end
        if (w < 0) begin
            total++;
            bad++;
            $display("FAIL spurious_ram_req: ram_req at cycle %0d, expected no access", c);
            return;
        end
        chk("grant_id", 128'(grant_id), 128'(w));
        chk("busy_at_issue", 128'(busy), 128'd1);
        chk("ram_addr", 128'(ram_addr), 128'(m_slot[w].addr));
        chk("ram_rnw", 128'(ram_rnw), 128'(m_slot[w].rnw));
        chk("ram_128", 128'(ram_128), 128'(m_slot[w].is128));
        chk("ram_din", 128'(ram_din), 128'(m_slot[w].din));
        e.id   = w;
        e.addr = m_slot[w].addr;
        if ($urandom_range(7) == 0) begin
            e.to    = 1'b1;
            e.at    = c + TO + 1;
            rdy_at  = -100;
            rdy_len = 0;
        end else begin
            d        = $urandom_range(12, 1);
            rdy_at   = c + d;
            rdy_len  = $urandom_range(3, 1);
            rdy_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            e.to     = 1'b0;
            e.at     = c + d + 1;
            if (m_slot[w].rnw) m_dout = rdy_data;
        end
        e.dout = m_dout;
        sbq.push_back(e);
        m_done[w] = e.at;
        m_last    = w;
    endtask

    task automatic done_side();
        exp_t e;
        done_seen++;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: rq_done=%b rq_timeout=%b, expected none", rq_done,
                     rq_timeout);
            return;
        end
        e = sbq.pop_front();
        chk("done_id", 128'(rq_done), 128'(3'b001 << e.id));
        chk("done_cycle", 128'(cyc), 128'(e.at));
        chk("timeout_flag", 128'(rq_timeout), e.to ? 128'(3'b001 << e.id) : 128'd0);
        chk("rq_dout", rq_dout, e.dout);
        chk("ram_addr_held", 128'(ram_addr), 128'(e.addr));
    endtask

    always @(negedge clk1x) begin
        if (ram_req) begin
            if (manual) manual_reqs++;
            else ram_side(cyc);
        end
        if (rq_done != '0 || rq_timeout != '0) done_side();
    end

    always @(posedge clk1x) begin
        #1;
        ram_ready = force_rdy || (cyc >= rdy_at && cyc < rdy_at + rdy_len);
        ram_dout  = ram_ready ? rdy_data : {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    task automatic pulse_reset();
        @(posedge clk1x);
        #1;
        reset  = 1'b1;
        rq_req = '0;
        f_req  = '0;
        @(posedge clk1x);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        int n = 0;
        stim_on = 1'b0;
        while ((sbq.size() != 0 || any_pend()) && n < 400) begin
            stim_cycle();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL drain: %0d completions still outstanding, expected 0", sbq.size());
        end
        repeat (2) stim_cycle();
        @(negedge clk1x);
        chk("idle_after_drain", 128'(busy), 128'd0);
        chk("err_overrun", 128'(err_overrun), 128'(m_err));
    endtask

    // Fixed priority: requester 0 re-requests in each DONE cycle and keeps 1 and 2 starved.
    task automatic run_fixed();
        int order[$];
        int f_rdy_at = -100;
        int n_other  = 0;
        f_addr[1] = 27'h100;
        f_addr[2] = 27'h200;
        @(posedge clk1x);
        #1;
        f_req = 3'b111;
        for (int k = 0; k < 150 && order.size() < 4; k++) begin
            @(negedge clk1x);
            if (f_ram_req) begin
                order.push_back(int'(f_grant_id));
                chk("fix_addr", 128'(f_ram_addr), 128'd0);
                f_rdy_at = cyc + 3;
            end
            if (f_done[2:1] != 2'b00) n_other++;
            @(posedge clk1x);
            #1;
            f_req   = (cyc == f_rdy_at + 1) ? 3'b001 : 3'b000;
            f_ready = (cyc == f_rdy_at);
        end
        f_req   = '0;
        f_ready = 1'b0;
        chk("fix_grants", 128'(order.size()), 128'd4);
        for (int k = 0; k < order.size(); k++) chk("fix_order", 128'(order[k]), 128'd0);
        chk("fix_starve", 128'(n_other), 128'd0);
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        rq_req    = '0;
        rq_addr   = '0;
        rq_rnw    = '0;
        rq_128    = '0;
        rq_din    = '0;
        manual    = 1'b0;
        stim_on   = 1'b0;
        force_rdy = 1'b0;
        req_pct   = 0;
        manual_reqs = 0;
        done_seen   = 0;
        rdy_data    = '0;
        model_reset();
        repeat (3) @(posedge clk1x);
        #1 reset = 1'b0;
        @(negedge clk1x);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ram_req", 128'(ram_req), 128'd0);
        chk("rst_done", 128'(rq_done), 128'd0);
        chk("rst_timeout", 128'(rq_timeout), 128'd0);
        chk("rst_err", 128'(err_overrun), 128'd0);
        chk("rst_grant", 128'(grant_id), 128'd0);
        chk("rst_dout", rq_dout, 128'd0);
        chk("rst_ram_addr", 128'(ram_addr), 128'd0);

        run_fixed();
        pulse_reset();

        for (int r = 0; r < 6; r++) begin
            req_pct = (r < 2) ? 2 : 15;
            stim_on = 1'b1;
            repeat (300) stim_cycle();
            drain();
            pulse_reset();
        end

        // Reset while waiting for ready: the access is abandoned and its late ready ignored.
        manual = 1'b1;
        @(posedge clk1x);
        #1;
        rq_req = 3'b001;
        rq_rnw = 3'b001;
        @(posedge clk1x);
        #1;
        rq_req = '0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk1x);
            seen = ram_req;
        end
        chk("midwait_issue", 128'(seen), 128'd1);
        repeat (3) @(posedge clk1x);
        pulse_reset();
        manual_reqs = 0;
        done_seen   = 0;
        @(negedge clk1x);
        chk("midwait_busy", 128'(busy), 128'd0);
        chk("midwait_ram_req", 128'(ram_req), 128'd0);
        chk("midwait_err", 128'(err_overrun), 128'd0);
        @(posedge clk1x);
        #1 force_rdy = 1'b1;
        repeat (2) @(posedge clk1x);
        #1 force_rdy = 1'b0;
        repeat (20) @(posedge clk1x);
        @(negedge clk1x);
        chk("midwait_no_done", 128'(done_seen), 128'd0);
        chk("midwait_no_reissue", 128'(manual_reqs), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
